// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl
// Desc     : Multi-cycle MIPS control sequencer with memory-handshake watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       reg_we,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_src,
    output logic       alu_src,
    output logic [2:0] alu_op,
    output logic [1:0] ext_op,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic [2:0] state,
    output logic       illegal,
    output logic       timeout,
    output logic       retire
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        K_ADDU = 4'd0,
        K_SUBU = 4'd1,
        K_NOP  = 4'd2,
        K_ORI  = 4'd3,
        K_LUI  = 4'd4,
        K_LW   = 4'd5,
        K_SW   = 4'd6,
        K_BEQ  = 4'd7,
        K_J    = 4'd8,
        K_JAL  = 4'd9,
        K_JR   = 4'd10,
        K_ILL  = 4'd11
    } kind_t;

    localparam logic [CNT_W-1:0] c_limit = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    kind_t            w_kind;
    logic             w_wait;
    logic             w_tmo;
    logic             w_alu_src;
    logic [2:0]       w_alu_op;
    logic [1:0]       w_ext_op;

    assign state = r_state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if ((w_next != r_state) || w_tmo) begin
                r_cnt <= '0;
            end else if (w_wait) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_kind = K_ILL;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h21:   w_kind = K_ADDU;
                    6'h23:   w_kind = K_SUBU;
                    6'h00:   w_kind = K_NOP;
                    6'h08:   w_kind = K_JR;
                    default: w_kind = K_ILL;
                endcase
            end
            6'h02:   w_kind = K_J;
            6'h03:   w_kind = K_JAL;
            6'h04:   w_kind = K_BEQ;
            6'h0d:   w_kind = K_ORI;
            6'h0f:   w_kind = K_LUI;
            6'h23:   w_kind = K_LW;
            6'h2b:   w_kind = K_SW;
            default: w_kind = K_ILL;
        endcase
    end

    // ALU setup is reused in MEM and WB so address and result stay stable.
    always_comb begin
        w_alu_src = 1'b0;
        w_alu_op  = 3'd0;
        w_ext_op  = 2'd0;
        case (w_kind)
            K_SUBU, K_BEQ: w_alu_op = 3'd1;
            K_ORI: begin
                w_alu_op  = 3'd2;
                w_alu_src = 1'b1;
            end
            K_LUI: begin
                w_alu_op  = 3'd3;
                w_alu_src = 1'b1;
                w_ext_op  = 2'd2;
            end
            K_LW, K_SW: begin
                w_alu_src = 1'b1;
                w_ext_op  = 2'd1;
            end
            default: begin
                w_alu_src = 1'b0;
                w_alu_op  = 3'd0;
                w_ext_op  = 2'd0;
            end
        endcase
    end

    always_comb begin
        w_next   = r_state;
        w_wait   = 1'b0;
        w_tmo    = 1'b0;
        imem_req = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pc_src   = 2'd0;
        reg_we   = 1'b0;
        reg_dst  = 2'd0;
        wd_src   = 2'd0;
        alu_src  = 1'b0;
        alu_op   = 3'd0;
        ext_op   = 2'd0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        illegal  = 1'b0;
        timeout  = 1'b0;
        retire   = 1'b0;

        case (r_state)
            ST_IDLE: w_next = ST_FETCH;

            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we  = 1'b1;
                    pc_we  = 1'b1;
                    w_next = ST_DECODE;
                end else if (r_cnt >= c_limit) begin
                    w_tmo   = 1'b1;
                    timeout = 1'b1;
                end else begin
                    w_wait = 1'b1;
                end
            end

            ST_DECODE: begin
                case (w_kind)
                    K_J, K_JAL: begin
                        pc_we  = 1'b1;
                        pc_src = 2'd2;
                        retire = 1'b1;
                        w_next = ST_FETCH;
                        if (w_kind == K_JAL) begin
                            reg_we  = 1'b1;
                            reg_dst = 2'd2;
                            wd_src  = 2'd2;
                        end
                    end
                    K_JR: begin
                        pc_we  = 1'b1;
                        pc_src = 2'd3;
                        retire = 1'b1;
                        w_next = ST_FETCH;
                    end
                    K_ILL: begin
                        illegal = 1'b1;
                        w_next  = ST_FETCH;
                    end
                    default: w_next = ST_EXEC;
                endcase
            end

            ST_EXEC: begin
                alu_src = w_alu_src;
                alu_op  = w_alu_op;
                ext_op  = w_ext_op;
                case (w_kind)
                    K_ADDU, K_SUBU, K_NOP, K_ORI, K_LUI: w_next = ST_WB;
                    K_LW, K_SW: w_next = ST_MEM;
                    K_BEQ: begin
                        retire = 1'b1;
                        w_next = ST_FETCH;
                        if (zero) begin
                            pc_we  = 1'b1;
                            pc_src = 2'd1;
                        end
                    end
                    default: w_next = ST_FETCH;
                endcase
            end

            ST_MEM: begin
                alu_src  = w_alu_src;
                alu_op   = w_alu_op;
                ext_op   = w_ext_op;
                dmem_req = 1'b1;
                dmem_we  = (w_kind == K_SW);
                if (dmem_ready) begin
                    if (w_kind == K_SW) begin
                        retire = 1'b1;
                        w_next = ST_FETCH;
                    end else begin
                        w_next = ST_WB;
                    end
                end else if (r_cnt >= c_limit) begin
                    w_tmo   = 1'b1;
                    timeout = 1'b1;
                    w_next  = ST_FETCH;
                end else begin
                    w_wait = 1'b1;
                end
            end

            ST_WB: begin
                alu_src = w_alu_src;
                alu_op  = w_alu_op;
                ext_op  = w_ext_op;
                reg_we  = (w_kind != K_NOP);
                retire  = 1'b1;
                w_next  = ST_FETCH;
                if ((w_kind == K_ADDU) || (w_kind == K_SUBU) || (w_kind == K_NOP)) begin
                    reg_dst = 2'd1;
                end
                if (w_kind == K_LW) begin
                    wd_src = 2'd1;
                end
            end

            default: w_next = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control sequencer for the MIPS core. It replaces single-cycle combinational control with a registered FSM.
- Decodes the latched instruction (opcode/funct from IR) and drives every datapath strobe and mux select per state.
- Stalls on instruction-memory and data-memory ready handshakes, with a watchdog timeout.
- Sits between the IR/ALU-flag outputs of the datapath and its PC, IR, GRF, ALU, EXT and DM controls.

Parameters:
TIMEOUT, 16, max cycles to wait for imem_ready/dmem_ready before aborting (1..255)
CNT_W, 8, width of the wait counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU equal flag, valid in EXEC
imem_ready  in  1  instruction word valid this cycle
dmem_ready  in  1  data access completes this cycle
imem_req  out  1  instruction fetch request
ir_we  out  1  latch instruction into IR
pc_we  out  1  update PC
pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump imm26, 3 = GPR[rs]
reg_we  out  1  GRF write enable
reg_dst  out  2  0 = rt, 1 = rd, 2 = $31
wd_src  out  2  0 = ALU, 1 = DM read data, 2 = PC (already PC+4)
alu_src  out  1  0 = GPR[rt], 1 = extended imm
alu_op  out  3  0 = add, 1 = sub, 2 = or, 3 = pass-B
ext_op  out  2  0 = zero-ext, 1 = sign-ext, 2 = imm<<16
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write (with dmem_req)
state  out  3  current state encoding (debug)
illegal  out  1  one-cycle pulse on undecodable instruction
timeout  out  1  one-cycle pulse on handshake timeout
retire  out  1  one-cycle pulse when an instruction completes

Behaviour:
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5.
- Reset (reset==0, asynchronous): state=IDLE, wait counter=0. All outputs are 0, including pulses.
- Mid-operation reset aborts the instruction immediately. No partial strobes persist.
- IDLE: all strobes 0. Goes to FETCH on the first clk edge with reset high.
- FETCH:
  - imem_req=1.
  - If imem_ready: ir_we=1, pc_we=1, pc_src=0, next state DECODE.
  - Otherwise stay in FETCH and count.
- DECODE: GRF is read. Transitions by opcode:
  - j: pc_we=1, pc_src=2, retire=1, go to FETCH.
  - jal: as j, plus reg_we=1, reg_dst=2, wd_src=2.
  - R-type jr (funct 0x08): pc_we=1, pc_src=3, retire=1, go to FETCH.
  - R-type addu (0x21), subu (0x23), sll-nop (0x00), plus ori (0x0d), lui (0x0f), lw (0x23), sw (0x2b), beq (0x04): go to EXEC.
  - Anything else: illegal=1, no architectural write, go to FETCH. No retire.
- EXEC:
  - addu: alu_op=0, alu_src=0. subu: alu_op=1, alu_src=0. nop: alu_op=0. All three go to WB.
  - ori: alu_op=2, alu_src=1, ext_op=0, go to WB.
  - lui: alu_op=3, alu_src=1, ext_op=2, go to WB.
  - lw/sw: alu_op=0, alu_src=1, ext_op=1, go to MEM.
  - beq: alu_op=1, alu_src=0. If zero: pc_we=1, pc_src=1. Always retire=1, go to FETCH.
- MEM:
  - dmem_req=1; dmem_we=1 for sw. Control outputs are held stable while waiting.
  - On dmem_ready: sw retires and goes to FETCH; lw goes to WB.
- WB: reg_we=1, retire=1, go to FETCH.
  - R-type: reg_dst=1, wd_src=0.
  - ori/lui: reg_dst=0, wd_src=0.
  - lw: reg_dst=0, wd_src=1.
  - nop (sll, funct 0): reg_we is forced to 0 but it still retires.
- Wait counter:
  - Cleared on every state change.
  - Increments each cycle spent in FETCH or MEM without ready.
  - When it reaches TIMEOUT-1 while still not ready: timeout=1, go to FETCH (FETCH restarts the fetch; MEM abandons the access), no retire.
  - Ready arriving in the same cycle as the limit wins: normal completion, no timeout.
- Latency with zero-wait memory:
  - j/jal/jr: 2 cycles.
  - beq: 3 cycles.
  - addu/subu/ori/lui/sw: 4 cycles.
  - lw: 5 cycles.
  - Each wait cycle adds 1.
- Register rules: state and the counter are registered. All strobes are a combinational function of state, opcode, funct, zero and the ready inputs. Outputs are glitch-irrelevant (sampled at the edge).

Test Plan:
- Release reset at t=10 with imem_ready=1 tied, feed addu (op 0, funct 0x21) -> state sequence 0,1,2,3,5,1. reg_we=1 with reg_dst=1 only in WB. retire pulses once after 4 cycles.
- lw (op 0x23) with dmem_ready delayed 3 cycles -> MEM holds dmem_req=1, dmem_we=0 for 4 cycles. Then WB asserts wd_src=1, reg_dst=0. Total 8 cycles.
- beq (op 0x04) twice, with zero=1 then zero=0 -> first pass: pc_we=1, pc_src=1 in EXEC. Second pass: pc_we=0 in EXEC. Both retire, in 3 cycles each.
- jal (op 0x03) -> DECODE asserts pc_src=2, reg_we=1, reg_dst=2, wd_src=2. Next state FETCH. Repeat with jr -> pc_src=3, reg_we=0.
- imem_ready held 0 with TIMEOUT=16 -> timeout pulses after 16 cycles in FETCH. No ir_we; FETCH re-entered. Also drop reset mid-MEM of an sw -> outputs go 0 immediately and state=0.
- Opcode 0x3f -> illegal pulses in DECODE. No pc_we or reg_we beyond fetch; no retire. Next state FETCH.
